uart_rx_buffered: RTL
=====================

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 SHALL have parameter data_bits_p, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter parity_bit_p, default 0, where 1 means a parity bit follows the data bits.
REQ-003 SHALL have parameter parity_odd_p, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-004 SHALL have parameter stop_bits_p, default 1, stop bits per frame, 1 or 2.
REQ-005 SHALL have parameter div_width_p, default 16, width of the runtime bit divisor.
REQ-006 SHALL have parameter fifo_els_p, default 4, receive FIFO depth, at least 2.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-008 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-009 SHALL have port clk_per_bit_i, input, div_width_p bits: clocks per bit.
REQ-010 SHALL have port rx_i, input, 1 bit: asynchronous serial line, idle high, LSB first.
REQ-011 SHALL have port v_o, output, 1 bit: FIFO head valid.
REQ-012 SHALL have port data_o, output, data_bits_p bits: head data.
REQ-013 SHALL have port parity_err_o, output, 1 bit: head parity mismatch.
REQ-014 SHALL have port frame_err_o, output, 1 bit: head stop bit sampled low.
REQ-015 SHALL have port break_o, output, 1 bit: head data all zero and frame error.
REQ-016 SHALL have port yumi_i, input, 1 bit: consumer pops head; legal only while v_o=1.
REQ-017 SHALL have port overrun_o, output, 1 bit: sticky, a frame was dropped on a full FIFO.
REQ-018 SHALL have port clear_i, input, 1 bit: clears overrun_o.

Function
REQ-019 SHALL pass rx_i through a 2-flop synchronizer that resets to 1; all sampling uses the synchronized value.
REQ-020 SHALL implement states e_idle, e_start, e_data, e_parity, e_stop, e_wait_high.
REQ-021 SHALL, in e_idle, on synchronized low, latch clk_per_bit_i into the divisor register, clear the bit counter, and go to e_start; clk_per_bit_i changes mid-frame SHALL be ignored.
REQ-022 SHALL treat latched divisor values below 4 as 4.
REQ-023 SHALL, in e_start, sample at count (div-1)>>1: low goes to e_data with the counter cleared; high returns to e_idle with no push and no error.
REQ-024 SHALL, in e_data, sample at count div-1, store bit[idx] LSB first, and after data_bits_p samples go to e_parity if parity_bit_p=1, else e_stop.
REQ-025 SHALL, in e_parity, sample at div-1 and set parity_err = (XOR of data bits) ^ sample ^ parity_odd_p.
REQ-026 SHALL, in e_stop, sample each of the stop_bits_p stop bits at div-1; any low sample sets frame_err.
REQ-027 SHALL, on the last stop sample, push {break, frame_err, parity_err, data} into the FIFO that cycle and then go to e_idle, or to e_wait_high if that sample was low.
REQ-028 SHALL, in e_wait_high, remain until the synchronized line is high, then go to e_idle.
REQ-029 SHALL make a push visible on v_o on the cycle after the push cycle when the FIFO was empty.
REQ-030 SHALL, on a push into a full FIFO without yumi_i that cycle, drop the frame and set overrun_o=1 from the next cycle.
REQ-031 SHALL, on a push with yumi_i in the same cycle on a full FIFO, accept the push with no overrun.
REQ-032 SHALL, when clear_i and a new overrun coincide, leave overrun_o set.
REQ-033 SHALL hold data_o and all status outputs stable while v_o=1 and yumi_i=0.

Reset
REQ-034 SHALL, on reset_i, asynchronously force e_idle, empty the FIFO, clear all counters, set the synchronizer flops to 1, and drive v_o=0 and overrun_o=0.
REQ-035 SHALL discard any frame in progress on reset; after reset deassertion, reception SHALL restart only on a fresh low.

Configuration
REQ-036 SHALL, with UART_RX_MAJORITY_EN defined, use as each sample value the 2-of-3 majority of the synchronized line over the sample cycle and the two preceding cycles.
REQ-037 SHALL, without UART_RX_MAJORITY_EN, use the single synchronized value at the sample cycle, with no extra flops.

Structure
REQ-038 SHALL define the state enum and the status struct {break, frame_err, parity_err} in the shared package uart_pkg.
REQ-039 SHALL instantiate bsg_fifo_1r1w_small as the sole sub-module for buffering, with width data_bits_p+3.

Verification
REQ-040 SHALL cover: divisor 16, 8N1, byte 0xA5 sent → one entry, data_o=0xA5, all errors 0, v_o high within 10*16+4 cycles of the start edge.
REQ-041 SHALL cover: parity_bit_p=1 with even parity, byte 0x03 sent with a parity bit of 1 → parity_err_o=1, data_o=0x03.
REQ-042 SHALL cover: line held low for 20 bit times → exactly one entry with data 0x00, frame_err_o=1, break_o=1, and no further entries until the line returns high.
REQ-043 SHALL cover: fifo_els_p=2, three bytes 0x11, 0x22, 0x33 sent with no yumi_i → entries 0x11 and 0x22, overrun_o=1; a clear_i pulse returns overrun_o to 0.
REQ-044 SHALL cover: a 3-cycle low glitch at divisor 16 → no entry, no error; then reset_i asserted mid-data of 0x5A → v_o=0 and the next 0x5A is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the buffered UART receiver: frame FSM states and per-entry status.
package uart_pkg;

    typedef enum logic [2:0] {
        e_idle,
        e_start,
        e_data,
        e_parity,
        e_stop,
        e_wait_high
    } state_e;

    typedef struct packed {
        logic brk;
        logic frame_err;
        logic parity_err;
    } status_s;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Valid/yumi handshake bundle: master offers v/data, slave answers yumi when it takes the item.
interface uart_rx_buffered_if #(
    parameter int width_p = 11
) ();

    logic               v;
    logic [width_p-1:0] data;
    logic               yumi;

    modport master (output v, output data, input yumi);
    modport slave  (input v, input data, output yumi);

endinterface

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO; a push into a full FIFO is still taken when the head pops that cycle.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 11,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    uart_rx_buffered_if.slave  enq_i,
    uart_rx_buffered_if.master deq_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_rd_ptr;
    logic [ptr_w_lp-1:0] r_wr_ptr;
    logic [cnt_w_lp-1:0] r_count;
    logic                w_full;
    logic                w_valid;
    logic                w_enq;
    logic                w_deq;

    assign w_full      = (r_count == cnt_w_lp'(els_p));
    assign w_valid     = (r_count != '0);
    assign w_deq       = w_valid & deq_o.yumi;
    assign w_enq       = enq_i.v & (~w_full | w_deq);
    assign enq_i.yumi  = w_enq;
    assign deq_o.v     = w_valid;
    assign deq_o.data  = r_mem[r_rd_ptr];

    // NOTE: storage carries no reset; the count alone decides which slots are live.
    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wr_ptr] <= enq_i.data;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= (r_wr_ptr == last_ptr_lp) ? '0 : r_wr_ptr + ptr_w_lp'(1);
            if (w_deq) r_rd_ptr <= (r_rd_ptr == last_ptr_lp) ? '0 : r_rd_ptr + ptr_w_lp'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + cnt_w_lp'(1);
                2'b01:   r_count <= r_count - cnt_w_lp'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver: 2-flop synchronizer, frame FSM and a receive FIFO with sticky overrun.
// Define UART_RX_MAJORITY_EN to take each bit sample as a 2-of-3 vote over the last three cycles.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int data_bits_p  = 8,
    parameter int parity_bit_p = 0,
    parameter int parity_odd_p = 0,
    parameter int stop_bits_p  = 1,
    parameter int div_width_p  = 16,
    parameter int fifo_els_p   = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [div_width_p-1:0] clk_per_bit_i,
    input  logic                   rx_i,
    output logic                   v_o,
    output logic [data_bits_p-1:0] data_o,
    output logic                   parity_err_o,
    output logic                   frame_err_o,
    output logic                   break_o,
    input  logic                   yumi_i,
    output logic                   overrun_o,
    input  logic                   clear_i
);

    localparam int width_lp = data_bits_p + 3;
    localparam int idx_w_lp = $clog2(data_bits_p);
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(data_bits_p - 1);
    localparam logic parity_en_lp  = (parity_bit_p != 0);
    localparam logic parity_odd_lp = (parity_odd_p != 0);
    localparam logic two_stop_lp   = (stop_bits_p == 2);

    logic [1:0]             r_sync;
    logic                   w_rx;
    logic                   w_sample;
    state_e                 r_state;
    logic [div_width_p-1:0] r_div;
    logic [div_width_p-1:0] r_cnt;
    logic [div_width_p-1:0] w_div_in;
    logic [div_width_p-1:0] w_half;
    logic [div_width_p-1:0] w_last;
    logic [idx_w_lp-1:0]    r_idx;
    logic                   r_stop_idx;
    logic [data_bits_p-1:0] r_data;
    logic                   r_parity_err;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   w_bit_end;
    logic                   w_stop_last;
    logic                   w_push;
    status_s                w_status;
    status_s                w_head_status;

    uart_rx_buffered_if #(.width_p(width_lp)) enq_if ();
    uart_rx_buffered_if #(.width_p(width_lp)) deq_if ();

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_sync <= 2'b11;
        else         r_sync <= {r_sync[0], rx_i};
    end
    assign w_rx = r_sync[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_hist <= 2'b11;
        else         r_hist <= {r_hist[0], w_rx};
    end
    assign w_sample = majority3(w_rx, r_hist[0], r_hist[1]);
`else
    assign w_sample = w_rx;
`endif

    assign w_div_in    = (clk_per_bit_i < div_width_p'(4)) ? div_width_p'(4) : clk_per_bit_i;
    assign w_last      = r_div - div_width_p'(1);
    assign w_half      = w_last >> 1;
    assign w_bit_end   = (r_cnt == w_last);
    assign w_stop_last = (r_stop_idx == two_stop_lp);

    // NOTE: the push is combinational so the entry is written on the last stop sample itself.
    assign w_push               = (r_state == e_stop) && w_bit_end && w_stop_last;
    assign w_status.frame_err   = r_frame_err | ~w_sample;
    assign w_status.parity_err  = r_parity_err;
    assign w_status.brk         = (r_data == '0) && w_status.frame_err;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= e_idle;
            r_div        <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_stop_idx   <= 1'b0;
            r_data       <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            case (r_state)
                e_idle: if (!w_rx) begin
                    r_div        <= w_div_in;
                    r_cnt        <= '0;
                    r_idx        <= '0;
                    r_parity_err <= 1'b0;
                    r_frame_err  <= 1'b0;
                    r_state      <= e_start;
                end
                e_start: if (r_cnt == w_half) begin
                    r_cnt   <= '0;
                    r_state <= w_sample ? e_idle : e_data;
                end else r_cnt <= r_cnt + div_width_p'(1);
                e_data: if (w_bit_end) begin
                    r_cnt         <= '0;
                    r_data[r_idx] <= w_sample;
                    r_stop_idx    <= 1'b0;
                    if (r_idx == last_idx_lp) r_state <= parity_en_lp ? e_parity : e_stop;
                    else                      r_idx   <= r_idx + idx_w_lp'(1);
                end else r_cnt <= r_cnt + div_width_p'(1);
                e_parity: if (w_bit_end) begin
                    r_cnt        <= '0;
                    r_parity_err <= (^r_data) ^ w_sample ^ parity_odd_lp;
                    r_state      <= e_stop;
                end else r_cnt <= r_cnt + div_width_p'(1);
                e_stop: if (w_bit_end) begin
                    r_cnt       <= '0;
                    r_frame_err <= w_status.frame_err;
                    r_stop_idx  <= 1'b1;
                    if (w_stop_last) r_state <= w_sample ? e_idle : e_wait_high;
                end else r_cnt <= r_cnt + div_width_p'(1);
                e_wait_high: if (w_rx) r_state <= e_idle;
                default: r_state <= e_idle;
            endcase
        end
    end

    assign enq_if.v    = w_push;
    assign enq_if.data = {w_status, r_data};

    bsg_fifo_1r1w_small #(
        .width_p(width_lp),
        .els_p  (fifo_els_p)
    ) fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .enq_i  (enq_if),
        .deq_o  (deq_if)
    );

    // A frame dropped on a full FIFO wins over a coincident clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_overrun <= 1'b0;
        else         r_overrun <= (w_push & ~enq_if.yumi) | (r_overrun & ~clear_i);
    end

    assign deq_if.yumi   = yumi_i;
    assign w_head_status = deq_if.data[width_lp-1 -: 3];
    assign v_o           = deq_if.v;
    assign data_o        = deq_if.data[data_bits_p-1:0];
    assign parity_err_o  = w_head_status.parity_err;
    assign frame_err_o   = w_head_status.frame_err;
    assign break_o       = w_head_status.brk;
    assign overrun_o     = r_overrun;

endmodule
